// File: rtl/uart_fx_master.sv
// UART command-frame master: turns CMD/A2/A1/A0[/D] byte frames into fx bus
// write and read cycles and hands read data back to the UART transmitter.
module uart_fx_master #(
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        rx_vld,
  input  logic [7:0]  rx_data,
  output logic        tx_vld,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  output logic        ufx_wr,
  output logic [21:0] ufx_waddr,
  output logic [7:0]  ufx_data,
  output logic        ufx_rd,
  output logic [21:0] ufx_raddr,
  input  logic [7:0]  ufx_q,
  output logic        frm_err
);

  typedef enum logic [3:0] {
    IDLE, ADR2, ADR1, ADR0, DAT, WR, RD, WAIT, TX
  } state_t;

  localparam logic [7:0]  CMD_WR   = 8'h57;
  localparam logic [7:0]  CMD_RD   = 8'h52;
  localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        isWr_q, isWr_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] to_q, to_d;
  logic [2:0]  lat_q, lat_d;
  logic        wr_q, wr_d;
  logic [21:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic [21:0] raddr_q, raddr_d;
  logic        txv_q, txv_d;
  logic [7:0]  txd_q, txd_d;
  logic        err_q, err_d;

  logic [23:0] addrShift;
  logic        inFrame;
  logic        busBusy;

  assign addrShift = {addr_q[15:0], rx_data};
  assign inFrame   = (state_q == ADR2) || (state_q == ADR1) ||
                     (state_q == ADR0) || (state_q == DAT);
  assign busBusy   = (state_q == WR) || (state_q == RD) ||
                     (state_q == WAIT) || (state_q == TX);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      isWr_q  <= 1'b0;
      addr_q  <= '0;
      to_q    <= '0;
      lat_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      raddr_q <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      isWr_q  <= isWr_d;
      addr_q  <= addr_d;
      to_q    <= to_d;
      lat_q   <= lat_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
    end
  end

  // Bus strobes, tx_vld and frm_err are all registered, so each is set on the
  // edge that enters its state and is cleared by the default on the next one.
  always_comb begin
    state_d = state_q;
    isWr_d  = isWr_q;
    addr_d  = addr_q;
    to_d    = '0;
    lat_d   = lat_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    raddr_d = raddr_q;
    txv_d   = 1'b0;
    txd_d   = txd_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            state_d = ADR2;
            isWr_d  = (rx_data == CMD_WR);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADR2: begin
        if (rx_vld) begin
          addr_d  = addrShift;
          state_d = ADR1;
        end
      end
      ADR1: begin
        if (rx_vld) begin
          addr_d  = addrShift;
          state_d = ADR0;
        end
      end
      ADR0: begin
        if (rx_vld) begin
          addr_d = addrShift;
          if (isWr_q) begin
            state_d = DAT;
          end else begin
            state_d = RD;
            rd_d    = 1'b1;
            raddr_d = addrShift[21:0];
          end
        end
      end
      DAT: begin
        if (rx_vld) begin
          state_d = WR;
          wr_d    = 1'b1;
          waddr_d = addr_q[21:0];
          wdata_d = rx_data;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          txd_d   = ufx_q;
          txv_d   = 1'b1;
          state_d = TX;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      TX: begin
        txv_d = 1'b1;
        if (tx_rdy) begin
          txv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Inter-byte silence inside a frame drops the frame without a bus cycle.
    if (inFrame && !rx_vld) begin
      if (to_q == TO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 24'd1;
      end
    end

    if (busBusy && rx_vld) begin
      err_d = 1'b1;
    end
  end

  assign ufx_wr    = wr_q;
  assign ufx_waddr = waddr_q;
  assign ufx_data  = wdata_q;
  assign ufx_rd    = rd_q;
  assign ufx_raddr = raddr_q;
  assign tx_vld    = txv_q;
  assign tx_data   = txd_q;
  assign frm_err   = err_q;

endmodule

// File: doc/uart_fx_master.md
# uart_fx_master

Command-frame master that converts the byte stream from the UART receiver into fx bus write and read cycles, and returns read data to the UART transmitter. It drives the master side of the fx bus interconnect (ufx_* signals), which broadcasts writes and reads to all slaves and returns the OR of their read data on ufx_q. One outstanding transaction at a time; no pipelining of frames.

## Interface
- RD_LAT, 2: cycles from the ufx_rd pulse to valid ufx_q (slave read latency); legal 1..7.
- TIMEOUT, 100000: inter-byte timeout in clk_sys cycles inside a frame; legal 2..2^24-1.
- clk_sys  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_vld  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- tx_vld  output  1  tx_data valid; held until accepted.
- tx_data  output  8  byte to transmit.
- tx_rdy  input  1  transmitter accepts tx_data when tx_vld and tx_rdy are both high.
- ufx_wr  output  1  one-cycle write strobe.
- ufx_waddr  output  22  write address.
- ufx_data  output  8  write data.
- ufx_rd  output  1  one-cycle read strobe.
- ufx_raddr  output  22  read address.
- ufx_q  input  8  OR-combined slave read data.
- frm_err  output  1  one-cycle pulse on any dropped/malformed frame.

## Operation
- Frame format, bytes in order: CMD, A2, A1, A0 [, D]. CMD 0x57 = write (D follows), 0x52 = read (no D). Address = {A2,A1,A0}, bits 23:22 discarded; 22-bit result used.
- States: IDLE, ADR2, ADR1, ADR0, DAT, WR, RD, WAIT, TX.
- IDLE: rx_vld with 0x57/0x52 -> ADR2, latch command; any other byte -> stay IDLE, pulse frm_err.
- ADR2 -> ADR1 -> ADR0 on each rx_vld, shifting byte into the 24-bit address register MSB first.
- After A0: write -> DAT; read -> RD.
- DAT: rx_vld -> latch data, go WR.
- WR (1 cycle): ufx_wr=1, ufx_waddr=address, ufx_data=data; -> IDLE.
- RD (1 cycle): ufx_rd=1, ufx_raddr=address; -> WAIT.
- WAIT: count RD_LAT cycles after the ufx_rd cycle; on the last one sample ufx_q into tx_data; -> TX.
- TX: tx_vld=1 until tx_rdy; on the accept cycle -> IDLE.
- ufx_waddr/ufx_data change only in WR; ufx_raddr only in RD; all hold between transactions.
- Timeout: counter cleared on every rx_vld and on entry to ADR2; counts while in ADR2/ADR1/ADR0/DAT. When TIMEOUT cycles pass with no rx_vld: -> IDLE, pulse frm_err, no bus cycle issued.
- rx_vld during WR/RD/WAIT/TX: byte discarded, frm_err pulsed; state unaffected.
- tx_rdy ignored when tx_vld=0.

## Timing
- Reset values: ufx_wr=0, ufx_rd=0, ufx_waddr=0, ufx_raddr=0, ufx_data=0, tx_vld=0, tx_data=0, frm_err=0, state IDLE, timeout counter 0.
- rst asserted in any state (including mid-frame, WAIT, or TX with tx_vld high) -> all of the above on the next edge; partial frame lost, no frm_err.
- Write: D strobe at cycle N -> ufx_wr high in cycle N+1 only.
- Read: A0 strobe at cycle N -> ufx_rd high in cycle N+1; ufx_q sampled at edge ending cycle N+1+RD_LAT; tx_vld high from cycle N+2+RD_LAT.
- tx_rdy already high when tx_vld rises -> tx_vld high exactly one cycle.
- Next frame's CMD accepted earliest the cycle after WR, or the cycle after the TX accept.
- Timeout: last rx_vld at cycle N -> if none in N+1..N+TIMEOUT, frm_err pulses in cycle N+TIMEOUT+1 and state is IDLE; rx_vld at exactly N+TIMEOUT is accepted.
- frm_err is a registered single-cycle pulse; back-to-back errors give back-to-back pulses.

## Test plan
- Write: bytes 57 01 23 45 AA -> single ufx_wr pulse with ufx_waddr=0x012345, ufx_data=0xAA; ufx_rd never asserted, tx_vld stays 0.
- Read, RD_LAT=2: bytes 52 3F FF FF, slave model returns 0x5C on ufx_q two cycles after ufx_rd -> ufx_raddr=0x3FFFFF, tx_data=0x5C, tx_vld exactly at A0 cycle+4; with tx_rdy held low 10 cycles, tx_vld/tx_data stable until accept.
- Bad command: byte 0x41 then 57 00 00 10 01 -> one frm_err pulse, then normal write to 0x000010 data 0x01.
- Timeout, TIMEOUT=8: 57 00 then silence -> frm_err 9 cycles after last byte, no ufx_wr; following 52 00 00 01 performs a clean read.
- Overrun/upper bits: send 0x99 while in TX -> frm_err, tx_data unchanged; write frame 57 C0 00 01 33 -> ufx_waddr=0x000001.
- Reset mid-frame: rst during DAT, then 57 00 00 02 77 -> outputs zero after rst, no frm_err, single write to 0x000002 data 0x77.
